// File: rtl/matrix_scan_scheduler.sv
// Scan controller for a 32x32 LED panel: sequences rows/columns, drives pclk/latch/blank,
// and swaps the double-buffered board store at frame boundaries.
module matrix_scan_scheduler #(
    parameter int ROW_PAIRS = 16,
    parameter int COLS      = 32,
    parameter int ON_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_ready,
    output logic       buf_sel,
    output logic       swap_ack,
    output logic       rd_en,
    output logic [3:0] rd_row,
    output logic [4:0] rd_col,
    input  logic [7:0] rd_data_top,
    input  logic [7:0] rd_data_bot,
    output logic       R0,
    output logic       G0,
    output logic       B0,
    output logic       R1,
    output logic       G1,
    output logic       B1,
    output logic       pclk,
    output logic [3:0] A,
    output logic       lch,
    output logic       blank
);

    localparam logic [3:0]  LAST_ROW = 4'(ROW_PAIRS - 1);
    localparam logic [4:0]  LAST_COL = 5'(COLS - 1);
    localparam logic [15:0] LAST_ON  = 16'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY,
        FRAME_END
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  row_reg, row_next;
    logic [4:0]  col_reg, col_next;
    logic [1:0]  phase_reg, phase_next;
    logic [15:0] disp_cnt_reg, disp_cnt_next;
    logic        latch_cnt_reg, latch_cnt_next;
    logic        buf_sel_reg, buf_sel_next;
    logic        pending_reg, pending_next;
    logic [5:0]  rgb_reg, rgb_next;
    logic [3:0]  a_reg, a_next;

    // Piece code to {R,G,B}; unknown codes render dark.
    function automatic logic [2:0] decode_piece(input logic [7:0] code);
        logic [2:0] rgb;
        case (code)
            8'h4F:   rgb = 3'b101;
            8'h4C:   rgb = 3'b011;
            8'h4A:   rgb = 3'b011;
            8'h49:   rgb = 3'b110;
            8'h54:   rgb = 3'b100;
            8'h53:   rgb = 3'b010;
            8'h5A:   rgb = 3'b001;
            8'h23:   rgb = 3'b111;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

    // Half 0 is the top panel half and lands in the upper RGB bits.
    logic [1:0][7:0] half_data;
    logic [5:0]      decoded;

    assign half_data = {rd_data_bot, rd_data_top};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode
            assign decoded[(1 - gi) * 3 +: 3] = decode_piece(half_data[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            phase_reg     <= '0;
            disp_cnt_reg  <= '0;
            latch_cnt_reg <= 1'b0;
            buf_sel_reg   <= 1'b0;
            pending_reg   <= 1'b0;
            rgb_reg       <= '0;
            a_reg         <= '0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            phase_reg     <= phase_next;
            disp_cnt_reg  <= disp_cnt_next;
            latch_cnt_reg <= latch_cnt_next;
            buf_sel_reg   <= buf_sel_next;
            pending_reg   <= pending_next;
            rgb_reg       <= rgb_next;
            a_reg         <= a_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        phase_next     = phase_reg;
        disp_cnt_next  = disp_cnt_reg;
        latch_cnt_next = latch_cnt_reg;
        buf_sel_next   = buf_sel_reg;
        pending_next   = pending_reg;
        rgb_next       = rgb_reg;
        a_next         = a_reg;
        blank          = 1'b1;
        lch            = 1'b0;
        pclk           = 1'b0;
        rd_en          = 1'b0;
        swap_ack       = 1'b0;

        // A request arriving in FRAME_END is served directly there instead.
        if (frame_ready && state_reg != FRAME_END) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = SHIFT;
                    row_next   = '0;
                    col_next   = '0;
                    phase_next = '0;
                end
            end

            SHIFT: begin
                rd_en      = (phase_reg == 2'd0);
                pclk       = (phase_reg == 2'd3);
                phase_next = phase_reg + 2'd1;
                // Read data for this column is valid during p1.
                if (phase_reg == 2'd1) begin
                    rgb_next = decoded;
                end
                if (phase_reg == 2'd3) begin
                    if (col_reg == LAST_COL) begin
                        state_next     = LATCH;
                        col_next       = '0;
                        latch_cnt_next = 1'b0;
                        a_next         = row_reg;
                    end else begin
                        col_next = col_reg + 5'd1;
                    end
                end
            end

            LATCH: begin
                lch            = 1'b1;
                latch_cnt_next = 1'b1;
                if (latch_cnt_reg) begin
                    state_next    = DISPLAY;
                    disp_cnt_next = '0;
                end
            end

            DISPLAY: begin
                blank         = 1'b0;
                disp_cnt_next = disp_cnt_reg + 16'd1;
                if (disp_cnt_reg == LAST_ON) begin
                    disp_cnt_next = '0;
                    if (row_reg != LAST_ROW) begin
                        state_next = SHIFT;
                        row_next   = row_reg + 4'd1;
                        col_next   = '0;
                        phase_next = '0;
                    end else begin
                        state_next = FRAME_END;
                    end
                end
            end

            FRAME_END: begin
                if (pending_reg || frame_ready) begin
                    swap_ack     = 1'b1;
                    buf_sel_next = ~buf_sel_reg;
                    pending_next = 1'b0;
                end
                row_next   = '0;
                col_next   = '0;
                phase_next = '0;
                state_next = enable ? SHIFT : IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign buf_sel = buf_sel_reg;
    assign rd_row  = row_reg;
    assign rd_col  = col_reg;
    assign A       = a_reg;
    assign {R0, G0, B0, R1, G1, B1} = rgb_reg;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Randomized bench for matrix_scan_scheduler against a frame-offset timeline model.
module tb_matrix_scan_scheduler;

    localparam int ROW_PAIRS = 16;
    localparam int COLS      = 32;
    localparam int ON_CYCLES = 4;
    localparam int RP        = 4 * COLS + 2 + ON_CYCLES;
    localparam int FL        = ROW_PAIRS * RP + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       frame_ready = 1'b0;
    logic       buf_sel, swap_ack, rd_en;
    logic [3:0] rd_row;
    logic [4:0] rd_col;
    logic [7:0] rd_data_top = 8'h00;
    logic [7:0] rd_data_bot = 8'h00;
    logic       R0, G0, B0, R1, G1, B1;
    logic       pclk, lch, blank;
    logic [3:0] A;

    always #5 clk = ~clk;

    matrix_scan_scheduler #(
        .ROW_PAIRS(ROW_PAIRS),
        .COLS     (COLS),
        .ON_CYCLES(ON_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_ready(frame_ready),
        .buf_sel    (buf_sel),
        .swap_ack   (swap_ack),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data_top(rd_data_top),
        .rd_data_bot(rd_data_bot),
        .R0         (R0),
        .G0         (G0),
        .B0         (B0),
        .R1         (R1),
        .G1         (G1),
        .B1         (B1),
        .pclk       (pclk),
        .A          (A),
        .lch        (lch),
        .blank      (blank)
    );

    // Board store: registered read, one cycle latency.
    logic [7:0] mem [2][32][32];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_top <= mem[buf_sel][{1'b0, rd_row}][rd_col];
            rd_data_bot <= mem[buf_sel][{1'b1, rd_row}][rd_col];
        end
    end

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model state: position within the current frame.
    int   k = 0;
    bit   running = 0;
    bit   bufm = 0;
    bit   req = 0;
    bit   a_chk = 1;
    bit   rgb_chk = 1;
    int   pclk_rises = 0;
    int   blank_low = 0;
    logic prev_pclk = 1'b0;
    logic prev_lch = 1'b0;
    logic prev_blank = 1'b1;

    function automatic logic [2:0] dec(input logic [7:0] b);
        case (b)
            8'h4F: return 3'b101;
            8'h4C: return 3'b011;
            8'h4A: return 3'b011;
            8'h49: return 3'b110;
            8'h54: return 3'b100;
            8'h53: return 3'b010;
            8'h5A: return 3'b001;
            8'h23: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: cycle %0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic fill_mem();
        logic [7:0] codes [9];
        codes = '{8'h4F, 8'h4C, 8'h4A, 8'h49, 8'h54, 8'h53, 8'h5A, 8'h20, 8'h23};
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++)
                    if ($urandom_range(3) != 0) mem[b][r][c] = codes[$urandom_range(8)];
                    else mem[b][r][c] = 8'($urandom);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit en, input bit fr, input bit rn);
        logic e_blank, e_lch, e_pclk, e_rden, e_ack;
        int   r, o, c, p;
        bit   in_shift, frame_end;
        @(negedge clk);
        enable = en;
        frame_ready = fr;
        reset = rn;
        #1;
        cyc++;
        e_blank = 1'b1; e_lch = 1'b0; e_pclk = 1'b0; e_rden = 1'b0; e_ack = 1'b0;
        r = 0; o = 0; c = 0; p = 0; in_shift = 0;
        frame_end = running && (k == FL - 1);
        if (frame_end) begin
            e_ack = req | fr;
        end else if (running) begin
            r = k / RP;
            o = k % RP;
            if (o < 4 * COLS) begin
                in_shift = 1;
                c = o / 4;
                p = o % 4;
                e_rden = (p == 0);
                e_pclk = (p == 3);
            end else if (o < 4 * COLS + 2) begin
                e_lch = 1'b1;
            end else begin
                e_blank = 1'b0;
            end
        end

        check_eq("ctl{blank,lch,pclk,rd_en,swap_ack,buf_sel}",
                 32'({blank, lch, pclk, rd_en, swap_ack, buf_sel}),
                 32'({e_blank, e_lch, e_pclk, e_rden, e_ack, bufm}));
        if (e_rden)
            check_eq("rd_addr", 32'({rd_row, rd_col}), 32'({4'(r), 5'(c)}));
        if (in_shift && p >= 2)
            check_eq("rgb", 32'({R0, G0, B0, R1, G1, B1}),
                     32'({dec(mem[bufm][r][c]), dec(mem[bufm][r + 16][c])}));
        else if (rgb_chk)
            check_eq("rgb_reset", 32'({R0, G0, B0, R1, G1, B1}), 32'(0));
        if (running && !frame_end && o >= 4 * COLS)
            check_eq("row_addr", 32'(A), 32'(r));
        else if (a_chk)
            check_eq("a_reset", 32'(A), 32'(0));

        if (!prev_pclk && pclk) pclk_rises++;
        if (!prev_lch && lch) begin
            check_eq("pclk_rises", 32'(pclk_rises), 32'(COLS));
            pclk_rises = 0;
        end
        if (!blank) blank_low++;
        else if (!prev_blank) begin
            check_eq("blank_low", 32'(blank_low), 32'(ON_CYCLES));
            blank_low = 0;
        end
        prev_pclk = pclk;
        prev_lch = lch;
        prev_blank = blank;

        if (!rn) begin
            running = 0; k = 0; bufm = 0; req = 0;
            a_chk = 1; rgb_chk = 1;
            pclk_rises = 0; blank_low = 0;
            prev_pclk = 1'b0; prev_lch = 1'b0; prev_blank = 1'b1;
        end else begin
            if (fr && !frame_end) req = 1;
            if (frame_end) begin
                if (req || fr) begin
                    bufm = ~bufm;
                    req = 0;
                end
                running = en;
                k = 0;
            end else if (running) begin
                if (in_shift && p == 1) rgb_chk = 0;
                if (o == 4 * COLS) a_chk = 0;
                k++;
            end else if (en) begin
                running = 1;
                k = 0;
            end
        end
    endtask

    task automatic run(input int n, input bit en, input int fr_pct);
        for (int i = 0; i < n; i++)
            step(en, ($urandom_range(99) < fr_pct), 1'b1);
    endtask

    task automatic run_until(input int target, input bit en);
        int budget;
        budget = 2 * FL;
        while (!(running && k == target) && budget > 0) begin
            step(en, 1'b0, 1'b1);
            budget--;
        end
        if (budget == 0)
            check_eq("run_until_timeout", 32'(k), 32'(target));
    endtask

    initial begin
        fill_mem();
        mem[0][0][0]  = 8'h4F;
        mem[0][16][0] = 8'h23;
        mem[0][0][1]  = 8'h41;
        mem[0][16][1] = 8'h41;

        reset = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);

        $display("-- reset held, release with enable=1");
        repeat (3) step(1'b1, 1'b0, 1'b0);

        $display("-- two frames without frame_ready");
        run(2 * FL, 1'b1, 0);

        $display("-- frame_ready mid-row 5");
        run_until(5 * RP + 20, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run_until(FL - 1, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        $display("-- three frame_ready pulses in one frame");
        run_until(RP + 3, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run_until(8 * RP + 50, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run_until(14 * RP + 130, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        run_until(FL - 1, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        $display("-- frame_ready inside FRAME_END");
        run_until(FL - 1, 1'b1);
        step(1'b1, 1'b1, 1'b1);

        $display("-- enable dropped during row 7 display");
        run_until(7 * RP + 4 * COLS + 3, 1'b1);
        run_until(FL - 1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run(20, 1'b0, 0);
        fill_mem();
        run(RP, 1'b1, 0);

        $display("-- reset during row 9 column 12");
        run_until(9 * RP + 12 * 4, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(2 * RP, 1'b1, 0);

        $display("-- random enable and frame_ready traffic");
        begin
            bit en_r;
            en_r = 1'b1;
            for (int i = 0; i < 3 * FL; i++) begin
                if ($urandom_range(599) == 0) en_r = ~en_r;
                step(en_r, ($urandom_range(199) == 0), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
